// File: rtl/adders_pkg.sv
// Shared definitions for the adder family: FSM state encoding and the
// index-width helper used to size slice counters.
package adders_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Width of a counter that indexes n slices; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational N-bit ripple-carry chain of full-adder cells.
module rca_slice #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);

   logic [N:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[N];

endmodule

// File: rtl/serial_rca_adder.sv
// Digit-serial adder/subtractor: one CHUNK-bit slice per cycle, LSB first,
// with the inter-slice carry held in a register. Valid/ready on both sides.
module serial_rca_adder
   import adders_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
   localparam int IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   if (CHUNK == 0 || (WIDTH % ((CHUNK == 0) ? 1 : CHUNK)) != 0) begin : g_bad_param
      $error("serial_rca_adder: WIDTH must be a positive multiple of CHUNK");
   end

   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;

   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic [CHUNK-1:0] slice_s;
   logic             slice_co;

   // Slice select as a shift keeps the mux legal when NCHUNK==1.
   assign slice_a = CHUNK'(a_q >> (idx * CHUNK));
   assign slice_b = CHUNK'(b_q >> (idx * CHUNK));

   rca_slice #(.N(CHUNK)) u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   assign in_ready  = (state == ST_IDLE) && !rst;
   assign out_valid = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         carry_q <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // sub is folded into the inverted B and the initial carry,
               // so it needs no register of its own.
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b ^ {WIDTH{sub}};
                  carry_q <= sub ? ~cin : cin;
                  idx     <= '0;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               for (int k = 0; k < NCHUNK; k++) begin
                  if (idx == IW'(k)) sum[k*CHUNK +: CHUNK] <= slice_s;
               end
               carry_q <= slice_co;
               if (idx == LAST) begin
                  state <= ST_DONE;
                  cout  <= slice_co;
                  ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (slice_s[CHUNK-1] != a_q[WIDTH-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_rca_adder.sv
// Directed and randomised checks of serial_rca_adder with a result scoreboard.
module tb_serial_rca_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int rnd_left = 3;
   bit rnd_go = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed instance, WIDTH=16 CHUNK=4 ----------------
   logic        rst, in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
   logic [15:0] a, b, sum;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   res_t exp_q[$];

   serial_rca_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   task automatic accept(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                         input logic xs, input bit push, input res_t e);
      chk("in_ready_idle", in_ready, 1'b1);
      a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
      if (push) exp_q.push_back(e);
      tick;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      int   k;
      res_t e;
      k = 0;
      while (!out_valid && k < 30) begin
         tick;
         k++;
      end
      chk({tag, "_lat"}, k, 4);
      e = exp_q.pop_front();
      chk({tag, "_sum"}, sum, e.sum);
      chk({tag, "_cout"}, cout, e.cout);
      chk({tag, "_ovf"}, ovf, e.ovf);
   endtask

   task automatic directed(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                           input logic xc, input logic xs, input res_t e);
      out_ready = 1'b1;
      accept(xa, xb, xc, xs, 1'b1, e);
      wait_result(tag);
      tick;
      chk({tag, "_consumed"}, out_valid, 1'b0);
   endtask

   // ---------------- randomised instances ----------------
   for (genvar g = 0; g < 3; g++) begin : g_rnd
      localparam int W  = (g == 0) ? 16 : (g == 1) ? 32 : 8;
      localparam int C  = (g == 0) ? 4  : 8;
      localparam int NC = W / C;

      logic [W-1:0] ra, rb, rs;
      logic         rv, rrdy, rov, rordy, rci, rsb, rco, rof;
      logic [W+1:0] q[$];

      serial_rca_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
         .clk(clk), .rst(rst), .in_valid(rv), .in_ready(rrdy),
         .a(ra), .b(rb), .cin(rci), .sub(rsb),
         .out_valid(rov), .out_ready(rordy),
         .sum(rs), .cout(rco), .ovf(rof)
      );

      // Reference from true integer arithmetic: {cout, ovf, sum}.
      function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci, input logic sb);
         longint ux, uy, sx, sy, ur, sr, smax, smin;
         logic   co, of;
         ux = longint'(x);
         uy = longint'(y);
         sx = x[W-1] ? ux - (longint'(1) << W) : ux;
         sy = y[W-1] ? uy - (longint'(1) << W) : uy;
         smax = (longint'(1) << (W - 1)) - 1;
         smin = -(longint'(1) << (W - 1));
         if (sb) begin
            ur = ux - uy - longint'(ci);
            sr = sx - sy - longint'(ci);
            co = (ux >= uy + longint'(ci));
         end else begin
            ur = ux + uy + longint'(ci);
            sr = sx + sy + longint'(ci);
            co = (ur >= (longint'(1) << W));
         end
         of = (sr > smax) || (sr < smin);
         return {co, of, W'(ur)};
      endfunction

      initial begin
         logic [W+1:0] e;
         int k, lat, st;
         rv = 1'b0; rordy = 1'b0; ra = '0; rb = '0; rci = 1'b0; rsb = 1'b0;
         wait (rnd_go);
         for (int n = 0; n < 1000; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = {1'b0, {(W-1){1'b1}}};
            if ($urandom_range(0, 7) == 0) rb = {1'b1, {(W-1){1'b0}}};
            if ($urandom_range(0, 7) == 0) rb = '1;
            rci = 1'($urandom);
            rsb = 1'($urandom);
            k = 0;
            while (!rrdy && k < 50) begin
               tick;
               k++;
            end
            rv = 1'b1;
            q.push_back(model(ra, rb, rci, rsb));
            tick;
            rv = 1'b0;
            ra = W'($urandom);
            lat = 0;
            rordy = 1'($urandom);
            while (!rov && lat < 50) begin
               tick;
               lat++;
               rordy = 1'($urandom);
            end
            chk($sformatf("rnd%0d_lat", g), lat, NC);
            st = 0;
            while (!rordy && st < 20) begin
               tick;
               st++;
               rordy = 1'($urandom);
            end
            rordy = 1'b1;
            e = q.pop_front();
            chk($sformatf("rnd%0d_sum", g), rs, e[W-1:0]);
            chk($sformatf("rnd%0d_cout", g), rco, e[W+1]);
            chk($sformatf("rnd%0d_ovf", g), rof, e[W]);
            tick;
            rordy = 1'b0;
         end
         rnd_left--;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int t;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      tick;
      tick;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, 16'h0000);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);

      directed("add_cout", 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0});
      directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});

      // Abort mid-operation: rst on the second BUSY edge clears the leftover ovf.
      accept(16'h1357, 16'h1111, 1'b0, 1'b0, 1'b0, '{16'h0, 1'b0, 1'b0});
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_sum", sum, 16'h0000);
      chk("abort_ovf", ovf, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      repeat (6) tick;
      chk("abort_no_result", out_valid, 1'b0);
      directed("after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0});

      directed("sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
      directed("sub_borrow1", 16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFD, 1'b0, 1'b0});
      directed("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
      directed("add_neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1});
      directed("add_cin",     16'h00FF, 16'h0F00, 1'b1, 1'b0, '{16'h1000, 1'b0, 1'b0});

      // Backpressure: result must hold while a new request is presented.
      out_ready = 1'b0;
      accept(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, '{16'h3333, 1'b0, 1'b0});
      wait_result("bp");
      in_valid = 1'b1;
      a = 16'hAAAA;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("bp_sum_hold", sum, 16'h3333);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      chk("bp_released", out_valid, 1'b0);
      chk("bp_in_ready_after", in_ready, 1'b1);
      tick;
      chk("bp_no_second_accept", in_ready, 1'b1);

      rnd_go = 1'b1;
      t = 0;
      while (rnd_left != 0 && t < 60000) begin
         tick;
         t++;
      end
      chk("rnd_complete", rnd_left, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
